// File: rtl/switch_led_pkg.sv
// Shared types and mode encodings for the switch-to-LED controller.
package switch_led_pkg;
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_DIRECT = 2'b00;
    localparam mode_t MODE_TOGGLE = 2'b01;
    localparam mode_t MODE_BLINK  = 2'b10;
    localparam mode_t MODE_INVERT = 2'b11;
endpackage

// File: rtl/switch_debounce.sv
// One switch channel: 2-FF synchroniser followed by a consecutive-edge counter debouncer.
module switch_debounce
    import switch_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // Any edge where the synchronised level agrees with the stable one restarts the count.
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_led_ctrl.sv
// Debounced switch bank driving registered LEDs in direct, toggle, blink or invert mode.
module switch_led_ctrl
    import switch_led_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_DIV       = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch,
    input  mode_t            mode,
    input  logic             clear,
    output logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] sw_stable,
    output logic             changed
);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [WIDTH-1:0] sw_stable_d;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] led_next;
    logic [BW-1:0]    blink_cnt;
    logic             phase;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .din (switch[i]),
            .dout(sw_stable[i])
        );
    end

    assign rise = sw_stable & ~sw_stable_d;

    always_comb begin
        led_next = sw_stable;
        unique case (mode)
            MODE_DIRECT: led_next = sw_stable;
            MODE_TOGGLE: led_next = tog;
            MODE_BLINK:  led_next = sw_stable & {WIDTH{phase}};
            MODE_INVERT: led_next = ~sw_stable;
            default:     led_next = sw_stable;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_stable_d <= '0;
            tog         <= '0;
            blink_cnt   <= '0;
            phase       <= 1'b0;
            led         <= '0;
            changed     <= 1'b0;
        end else begin
            sw_stable_d <= sw_stable;
            changed     <= |(sw_stable ^ sw_stable_d);
            // Latches track presses in every mode so entering toggle mode shows live state.
            tog         <= clear ? '0 : (tog ^ rise);
            led         <= led_next;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_switch_led_ctrl.sv
// Randomised bench for switch_led_ctrl against a sample-window reference model.
module tb_switch_led_ctrl;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int BD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] switch = '0;
    logic [1:0]   mode = 2'b00;
    logic         clear = 1'b0;
    logic [W-1:0] led;
    logic [W-1:0] sw_stable;
    logic         changed;

    switch_led_ctrl #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst(rst), .switch(switch), .mode(mode), .clear(clear),
        .led(led), .sw_stable(sw_stable), .changed(changed)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: raw samples per edge since reset, plus derived outputs.
    logic [W-1:0] hist[$];
    int           n_edge;
    logic [W-1:0] m_stable, m_stable_d, m_tog, m_led;
    logic         m_chg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        n_edge     = 0;
        m_stable   = '0;
        m_stable_d = '0;
        m_tog      = '0;
        m_led      = '0;
        m_chg      = 1'b0;
    endtask

    // A bit is accepted once the D raw samples that have reached sync2 all disagree with it.
    task automatic model_step(input logic [W-1:0] sw, input logic [1:0] md, input logic clr);
        logic [W-1:0] new_st;
        logic [W-1:0] s;
        logic         all_diff;
        logic         ph;
        n_edge++;
        hist.push_back(sw);
        new_st = m_stable;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int k = n_edge - D - 1; k <= n_edge - 2; k++) begin
                s = (k >= 1) ? hist[k-1] : '0;
                if (s[b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) new_st[b] = ~m_stable[b];
        end
        ph = (((n_edge - 1) / BD) % 2) == 1;
        case (md)
            2'b00:   m_led = m_stable;
            2'b01:   m_led = m_tog;
            2'b10:   m_led = ph ? m_stable : '0;
            default: m_led = ~m_stable;
        endcase
        m_chg      = (m_stable != m_stable_d);
        m_tog      = clr ? '0 : (m_tog ^ (m_stable & ~m_stable_d));
        m_stable_d = m_stable;
        m_stable   = new_st;
    endtask

    task automatic check_outputs();
        chk("led", 32'(led), 32'(m_led));
        chk("sw_stable", 32'(sw_stable), 32'(m_stable));
        chk("changed", 32'(changed), 32'(m_chg));
    endtask

    // Called at a negedge: drive, take one rising edge, compare at the following negedge.
    task automatic hold(input logic [W-1:0] sw, input logic [1:0] md, input logic clr, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            switch = sw;
            mode   = md;
            clear  = clr;
            @(posedge clk);
            model_step(sw, md, clr);
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_stable", 32'(sw_stable), 32'h0);
        chk("rst_changed", 32'(changed), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        model_reset();
        switch = 8'hFF;
        repeat (2) @(negedge clk);
        chk("init_led", 32'(led), 32'h0);
        chk("init_stable", 32'(sw_stable), 32'h0);
        chk("init_changed", 32'(changed), 32'h0);
        rst = 1'b0;

        // Reset / idle, then reset mid-debounce
        hold(8'hFF, 2'b00, 1'b0, 8);
        async_reset();
        hold(8'hFF, 2'b00, 1'b0, 3);
        async_reset();
        hold(8'hFF, 2'b00, 1'b0, 8);
        hold(8'h00, 2'b00, 1'b0, 10);

        // Glitch reject then a real value
        hold(8'h01, 2'b00, 1'b0, 3);
        hold(8'h00, 2'b00, 1'b0, 10);
        hold(8'hCD, 2'b00, 1'b0, 10);

        // Toggle
        hold(8'h00, 2'b01, 1'b1, 10);
        hold(8'h01, 2'b01, 1'b0, 10);
        hold(8'h00, 2'b01, 1'b0, 10);
        hold(8'h01, 2'b01, 1'b0, 10);
        hold(8'h00, 2'b01, 1'b0, 10);
        hold(8'h80, 2'b01, 1'b0, 10);
        hold(8'h00, 2'b01, 1'b0, 10);
        chk("toggle_led", 32'(led), 32'h80);
        hold(8'h08, 2'b01, 1'b1, 10);
        chk("toggle_clear", 32'(led), 32'h00);

        // Blink
        hold(8'hA5, 2'b10, 1'b0, 24);

        // Invert and back
        hold(8'h3C, 2'b00, 1'b0, 10);
        hold(8'h3C, 2'b11, 1'b0, 1);
        chk("invert_led", 32'(led), 32'hC3);
        hold(8'h3C, 2'b11, 1'b0, 2);
        hold(8'h3C, 2'b00, 1'b0, 1);
        chk("direct_led", 32'(led), 32'h3C);

        // Random soak with occasional short glitches
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                v = W'($urandom);
                hold(v, 2'b00, 1'b0, $urandom_range(1, 3));
            end
            v = W'($urandom);
            hold(v, 2'b00, 1'b0, 10);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
